// File: rtl/alu.sv
// RV32I-style execute-stage ALU: combinational result and flags from {funct7[5], funct3},
// plus one registered sticky bit recording any signed ADD/SUB overflow since reset.
module alu #(
  parameter int N               = 32,
  parameter int ALU_FUNCT_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N-1:0]               x,
  input  logic [N-1:0]               y,
  input  logic [ALU_FUNCT_WIDTH-1:0] funct,
  output logic [N-1:0]               z,
  output logic                       equal,
  output logic                       zero,
  output logic                       overflow,
  output logic                       ovf_sticky
);

  localparam int S = $clog2(N);

  typedef enum logic [ALU_FUNCT_WIDTH-1:0] {
    FN_ADD  = 4'b0000,
    FN_SLL  = 4'b0001,
    FN_SLT  = 4'b0010,
    FN_SLTU = 4'b0011,
    FN_XOR  = 4'b0100,
    FN_SRL  = 4'b0101,
    FN_OR   = 4'b0110,
    FN_AND  = 4'b0111,
    FN_SUB  = 4'b1000,
    FN_SRA  = 4'b1101
  } funct_e;

  logic [N-1:0] sum;
  logic [N-1:0] diff;
  logic [S-1:0] shamt;
  logic         lt_signed;
  logic         lt_unsigned;
  logic         ovf_add;
  logic         ovf_sub;
  logic         ovf_sticky_d;
  logic         ovf_sticky_q;

  assign sum         = x + y;
  assign diff        = x - y;
  // Only the low log2(N) bits of y select the shift; upper bits are ignored.
  assign shamt       = y[S-1:0];
  assign lt_signed   = $signed(x) < $signed(y);
  assign lt_unsigned = x < y;

  // Operands of equal sign producing a result of the other sign (SUB flips y's sign).
  assign ovf_add = (x[N-1] == y[N-1]) && (sum[N-1]  != x[N-1]);
  assign ovf_sub = (x[N-1] != y[N-1]) && (diff[N-1] != x[N-1]);

  // NOTE: every output of this always_comb is assigned a default first, so
  // unlisted function codes (and any future case edits) can never infer a latch.
  always_comb begin
    z        = '0;
    overflow = 1'b0;
    case (funct)
      FN_ADD:  begin z = sum;  overflow = ovf_add; end
      FN_SUB:  begin z = diff; overflow = ovf_sub; end
      FN_SLL:  z = x << shamt;
      FN_SLT:  z = {{(N-1){1'b0}}, lt_signed};
      FN_SLTU: z = {{(N-1){1'b0}}, lt_unsigned};
      FN_XOR:  z = x ^ y;
      FN_SRL:  z = x >> shamt;
      FN_SRA:  z = $unsigned($signed(x) >>> shamt);
      FN_OR:   z = x | y;
      FN_AND:  z = x & y;
      default: begin z = '0; overflow = 1'b0; end
    endcase
  end

  assign equal = (x == y);
  assign zero  = (z == '0);

  assign ovf_sticky_d = ovf_sticky_q | overflow;

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous
  // and checked first, so it wins over an overflow arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) ovf_sticky_q <= 1'b0;
    else        ovf_sticky_q <= ovf_sticky_d;
  end

  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: a driver pushes model predictions per vector, a negedge
// monitor pops and compares all DUT outputs, including the sticky overflow bit.
module tb_alu;

  typedef struct {
    logic [31:0] z;
    logic        eq;
    logic        zr;
    logic        ov;
    logic        st;
    int          id;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic [3:0]  funct = '0;
  logic [31:0] z;
  logic        equal, zero, overflow, ovf_sticky;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_issued = 0;

  // Reference state: what the sticky bit should hold after the latest edge.
  logic model_sticky = 1'b0;
  logic prev_rst_n   = 1'b0;
  logic prev_ovf     = 1'b0;

  alu #(.N(32), .ALU_FUNCT_WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .x          (x),
    .y          (y),
    .funct      (funct),
    .z          (z),
    .equal      (equal),
    .zero       (zero),
    .overflow   (overflow),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int id, input logic [31:0] got,
                       input logic [31:0] want);
    if (got !== want) begin
      n_err++;
      $display("FAIL %s (vector %0d): got %h, expected %h", name, id, got, want);
    end
  endtask

  // Behavioural model: signed/unsigned 64-bit arithmetic on the integer values.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] f);
    exp_t   e;
    longint sa = longint'($signed(a));
    longint sb_v = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    longint r;
    int     sh = int'(ub % 32);
    e.z  = '0;
    e.ov = 1'b0;
    case (f)
      4'b0000: begin r = sa + sb_v; e.z = r[31:0]; e.ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'b1000: begin r = sa - sb_v; e.z = r[31:0]; e.ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'b0001: begin r = ua * (64'sd1 << sh); e.z = r[31:0]; end
      4'b0010: e.z = (sa < sb_v) ? 32'd1 : 32'd0;
      4'b0011: e.z = (ua < ub) ? 32'd1 : 32'd0;
      4'b0100: e.z = a ^ b;
      4'b0101: begin r = ua / (64'sd1 << sh); e.z = r[31:0]; end
      4'b1101: begin r = sa >>> sh; e.z = r[31:0]; end
      4'b0110: e.z = a | b;
      4'b0111: e.z = a & b;
      default: e.z = '0;
    endcase
    e.eq = (a == b);
    e.zr = (e.z == 0);
    e.st = 1'b0;
    e.id = 0;
    return e;
  endfunction

  task automatic apply(input logic r, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] f);
    exp_t e;
    @(posedge clk);
    model_sticky = prev_rst_n ? (model_sticky | prev_ovf) : 1'b0;
    #2;
    rst_n = r;
    x     = a;
    y     = b;
    funct = f;
    e     = model(a, b, f);
    e.st  = model_sticky;
    e.id  = n_issued++;
    sb.push_back(e);
    prev_rst_n = r;
    prev_ovf   = e.ov;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: outputs are valid each negedge after the driver has issued a vector.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        check("z",          e.id, z,                  e.z);
        check("equal",      e.id, {31'd0, equal},     {31'd0, e.eq});
        check("zero",       e.id, {31'd0, zero},      {31'd0, e.zr});
        check("overflow",   e.id, {31'd0, overflow},  {31'd0, e.ov});
        check("ovf_sticky", e.id, {31'd0, ovf_sticky}, {31'd0, e.st});
      end
    end
  end

  initial begin
    // Reset edge, then directed cases.
    apply(1'b0, 32'd0,         32'd0,         4'b0000);
    apply(1'b1, 32'd5,         32'd7,         4'b0000);
    apply(1'b1, 32'h0000_0000, 32'h0000_0000, 4'b1000);
    apply(1'b1, 32'hFFFF_FFFF, 32'd1,         4'b0010);
    apply(1'b1, 32'hFFFF_FFFF, 32'd1,         4'b0011);
    apply(1'b1, 32'h8000_0000, 32'd4,         4'b1101);
    apply(1'b1, 32'h8000_0000, 32'd4,         4'b0101);
    apply(1'b1, 32'd1,         32'd33,        4'b0001);
    apply(1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0111);
    apply(1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0110);
    apply(1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0100);
    apply(1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b1111);
    // Sticky: set by an ADD overflow, held across clean ops, cleared by reset.
    apply(1'b1, 32'h7FFF_FFFF, 32'd1,         4'b0000);
    apply(1'b1, 32'd3,         32'd2,         4'b0100);
    apply(1'b1, 32'd3,         32'd2,         4'b0000);
    apply(1'b0, 32'd3,         32'd2,         4'b0000);
    apply(1'b1, 32'h8000_0000, 32'd1,         4'b1000);
    apply(1'b1, 32'd0,         32'd0,         4'b0110);
    // Reset and overflow together: reset must win.
    apply(1'b0, 32'h8000_0000, 32'h8000_0000, 4'b0000);
    apply(1'b1, 32'd0,         32'd0,         4'b0000);
    apply(1'b1, 32'd0,         32'd0,         4'b0000);

    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1, pick_operand(), pick_operand(),
            4'($urandom_range(0, 15)));
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drain", -1, 32'(sb.size()), 32'd0);
    check("vector_count", -1, 32'(n_vec), 32'(n_issued));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
